mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single clock; all state changes on posedge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 req_valid  in  1  CPU load/store request present.
REQ-004 req_ready  out  1  unit idle and can accept a request.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_signed  in  1  sign-extend loaded byte/half; ignored for word and store.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-012 resp_err  out  1  qualifies resp_valid; misaligned address or reserved size.
REQ-013 ram_cs, ram_oe, ram_we  out  1 each  word-RAM strobes.
REQ-014 ram_addr  out  32  word address {req_addr[31:2],2'b00}.
REQ-015 ram_din  out  32  write word to RAM.
REQ-016 ram_dout  in  32  RAM read word, valid the cycle after a cs&oe edge.

Function
REQ-017 Request accepted in cycle T when req_valid & req_ready; req_addr, req_size, req_we, req_signed, req_wdata captured at that edge; inputs ignored otherwise.
REQ-018 req_ready = 1 only in state IDLE.
REQ-019 States: IDLE, RD, LDW, MERGE, WR, RESP.
REQ-020 Error check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with resp_err=1; no RAM strobe.
REQ-021 Load: IDLE->RD (cs=oe=1)->LDW (ram_dout extracted, resp_rdata registered)->RESP; resp_valid in cycle T+3.
REQ-022 Store word: IDLE->WR (cs=we=1, ram_din=wdata)->RESP; resp_valid in cycle T+2.
REQ-023 Store byte/half: IDLE->RD->MERGE (old word with lane replaced, registered)->WR->RESP; resp_valid in cycle T+4; ram_we high only in WR.
REQ-024 Byte order big-endian: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; half offset 0 = [31:16], 2 = [15:0].
REQ-025 Loaded byte/half zero-extended when req_signed=0, sign-extended when 1.
REQ-026 RESP lasts exactly one cycle, then IDLE; no backpressure on the response.
REQ-027 ram_cs/ram_oe/ram_we decoded from current state only: RD -> cs,oe; WR -> cs,we; all other states -> 0.
REQ-028 ram_oe and ram_we never high in the same cycle.
REQ-029 ram_addr and ram_din stable from RD/WR entry through the strobing edge.
REQ-030 resp_rdata and resp_err hold their last value between pulses.

Reset
REQ-031 rst=1 forces IDLE immediately, independent of clk.
REQ-032 Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_cs/oe/we=0, ram_addr=0, ram_din=0.
REQ-033 Reset during any state aborts the operation: no response and no later RAM write; a pending read-modify-write leaves RAM unchanged.

Verification
REQ-034 Word 0x100 = 0x8899AABB; load word 0x100 -> resp_valid at T+3, resp_rdata=0x8899AABB, resp_err=0.
REQ-035 Signed load byte 0x101 -> 0xFFFFFF99; unsigned load byte 0x103 -> 0x000000BB.
REQ-036 Signed load half 0x102 -> 0xFFFFAABB; unsigned load half 0x100 -> 0x00008899.
REQ-037 Store byte 0x102, wdata 0x00000011 -> ram_oe at T+1, ram_we only at T+3, word 0x100 becomes 0x889911BB, resp_valid at T+4.
REQ-038 Load word 0x102 and store with size 11 -> resp_valid and resp_err at T+1, resp_rdata=0, ram_cs never asserted.
REQ-039 Store half 0x100 with rst pulsed in cycle T+2 -> ram_we never asserted, word stays 0x8899AABB, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU byte/half/word load-store unit in front of a big-endian word RAM (ports: req_* in, resp_* out, ram_* strobes).
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);
  typedef enum logic [2:0] {IDLE, RD, LDW, MERGE, WR, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic [31:0] addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
  logic bad;
  logic [4:0] lane_sh;
  logic [31:0] lane_mask, ld_val;
  logic [15:0] lane;
  assign bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && |req_addr[1:0]);
  // Big-endian lanes: byte offset k sits 8*(3-k) bits up, half offset 0 sits in the top half.
  assign lane_sh = (size_q == 2'd0) ? {~off_q, 3'b000} : {~off_q[1], 4'b0000};
  assign lane_mask = ((size_q == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff) << lane_sh;
  assign lane = 16'(ram_dout >> lane_sh);
  assign ld_val = (size_q == 2'd2) ? ram_dout :
                  (size_q == 2'd0) ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                                     {{16{sgn_q & lane[15]}}, lane[15:0]};
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    sgn_d = sgn_q;
    size_d = size_q;
    off_d = off_q;
    addr_d = addr_q;
    din_d = din_q;
    rdata_d = rdata_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        sgn_d = req_signed;
        size_d = req_size;
        off_d = req_addr[1:0];
        addr_d = {req_addr[31:2], 2'b00};
        din_d = req_wdata;
        // Errors report immediately; rdata/err only change on the edge into RESP.
        rdata_d = bad ? 32'h0 : rdata_q;
        err_d = bad ? 1'b1 : err_q;
        state_d = bad ? RESP : (req_we && req_size == 2'd2) ? WR : RD;
      end
      RD: state_d = we_q ? MERGE : LDW;
      LDW: begin
        rdata_d = ld_val;
        err_d = 1'b0;
        state_d = RESP;
      end
      // din_q still holds the right-aligned store data here; move it into its lane.
      MERGE: begin
        din_d = (ram_dout & ~lane_mask) | ((din_q << lane_sh) & lane_mask);
        state_d = WR;
      end
      WR: begin
        rdata_d = 32'h0;
        err_d = 1'b0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      addr_q <= 32'h0;
      din_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      sgn_q <= sgn_d;
      size_q <= size_d;
      off_q <= off_d;
      addr_q <= addr_d;
      din_q <= din_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  assign ram_cs = state_q == RD || state_q == WR;
  assign ram_oe = state_q == RD;
  assign ram_we = state_q == WR;
  assign ram_addr = addr_q;
  assign ram_din = din_q;
endmodule
